// File: rtl/input_fifo_register_if.sv
// Valid/ready operand bus between an upstream source, the operand FIFO and
// the ALU-side consumer. The slave modport is the FIFO's view; the master
// modport is the environment's (source plus consumer) view.
interface input_fifo_register_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/input_fifo_register.sv
// Operand FIFO in front of the ALU: buffers up to DEPTH words behind a
// valid/ready handshake, presents them in arrival order, and reports
// occupancy, almost-full and a sticky overflow flag for debug.
// All outputs come straight from registers or from a decode of the count,
// so there is no path from in_* to out_* and none from out_ready to in_ready.
module input_fifo_register #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input_fifo_register_if.slave       bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Decode occupancy and qualify the two handshakes; clear overrides both.
  // NOTE: every signal gets a default at the top of the block, so no path
  // through it can leave a value unassigned and infer a latch.
  always_comb begin
    full  = 1'b0;
    empty = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    full  = (count == CNT_W'(DEPTH));
    empty = (count == '0);
    push  = bus.in_valid  & ~full  & ~clear;
    pop   = bus.out_ready & ~empty & ~clear;
  end

  // Handshake and status outputs; in_ready looks only at count, never at
  // out_ready, so a full queue does not accept a word even during a pop.
  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_data  = mem[rd_ptr];
  assign almost_full   = (count >= CNT_W'(AFULL_LEVEL));

  // Storage array: written at wr_ptr on a push, never cleared by a pop.
  // NOTE: the array is deliberately reset so out_data reads a defined 0
  // after reset; this costs a reset net per storage flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: any write attempt against a full queue, held until
  // clear or reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (bus.in_valid && full) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_input_fifo_register.sv
// Directed bench for input_fifo_register (WIDTH=8, DEPTH=4, AFULL_LEVEL=3).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_input_fifo_register;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic [2:0] count;
  logic       almost_full;
  logic       overflow;

  int compared   = 0;
  int mismatched = 0;

  input_fifo_register_if #(.WIDTH(8)) bus ();

  input_fifo_register #(
    .WIDTH(8),
    .DEPTH(4),
    .AFULL_LEVEL(3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .bus        (bus),
    .count      (count),
    .almost_full(almost_full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic c);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    clear         = c;
  endtask

  logic [7:0] q[$];
  logic [7:0] next_word;
  logic       done;
  int         got;

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #12 reset_n = 1'b1;
    #1;

    // Reset state
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_count",     count,         0);
    check("rst_afull",     almost_full,   0);
    check("rst_overflow",  overflow,      0);

    // Fill 0x11..0x44 with out_ready=0
    drive(1'b1, 8'h11, 1'b0, 1'b0); step();
    check("fill1_count", count, 1); check("fill1_afull", almost_full, 0);
    check("fill1_head", bus.out_data, 8'h11); check("fill1_ovalid", bus.out_valid, 1);
    drive(1'b1, 8'h22, 1'b0, 1'b0); step();
    check("fill2_count", count, 2); check("fill2_afull", almost_full, 0);
    drive(1'b1, 8'h33, 1'b0, 1'b0); step();
    check("fill3_count", count, 3); check("fill3_afull", almost_full, 1);
    check("fill3_iready", bus.in_ready, 1);
    drive(1'b1, 8'h44, 1'b0, 1'b0); step();
    check("fill4_count", count, 4); check("fill4_iready", bus.in_ready, 0);
    check("fill4_head", bus.out_data, 8'h11);

    // Drain in order
    drive(1'b0, 8'h00, 1'b1, 1'b0); step();
    check("drain1_head", bus.out_data, 8'h22); check("drain1_count", count, 3);
    step();
    check("drain2_head", bus.out_data, 8'h33); check("drain2_count", count, 2);
    check("drain2_afull", almost_full, 0);
    step();
    check("drain3_head", bus.out_data, 8'h44); check("drain3_count", count, 1);
    step();
    check("drain4_ovalid", bus.out_valid, 0); check("drain4_count", count, 0);
    check("drain4_iready", bus.in_ready, 1);

    // Pop against empty queue must not underflow
    step();
    check("empty_pop_count", count, 0); check("empty_pop_ovalid", bus.out_valid, 0);

    // Refill, then write into a full queue while popping
    drive(1'b1, 8'hB1, 1'b0, 1'b0); step();
    drive(1'b1, 8'hB2, 1'b0, 1'b0); step();
    drive(1'b1, 8'hB3, 1'b0, 1'b0); step();
    drive(1'b1, 8'hB4, 1'b0, 1'b0); step();
    check("refill_count", count, 4); check("refill_overflow", overflow, 0);
    drive(1'b1, 8'h55, 1'b1, 1'b0); step();
    check("ovf_flag", overflow, 1); check("ovf_count", count, 3);
    check("ovf_head", bus.out_data, 8'hB2);
    drive(1'b0, 8'h00, 1'b0, 1'b0); step();
    check("ovf_sticky", overflow, 1);
    drive(1'b0, 8'h00, 1'b1, 1'b0); step();
    step();
    check("ovf_head3", bus.out_data, 8'hB4); check("ovf_count1", count, 1);
    check("ovf_sticky2", overflow, 1);
    step();
    check("ovf_drained_count", count, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b1); step();
    check("ovf_cleared", overflow, 0);

    // Simultaneous push and pop at count=2
    drive(1'b1, 8'hC1, 1'b0, 1'b0); step();
    drive(1'b1, 8'hC2, 1'b0, 1'b0); step();
    check("sim_pre_count", count, 2);
    drive(1'b1, 8'hA0, 1'b1, 1'b0); step();
    check("sim_count", count, 2); check("sim_head", bus.out_data, 8'hC2);
    drive(1'b0, 8'h00, 1'b1, 1'b0); step();
    check("sim_a0_head", bus.out_data, 8'hA0); check("sim_a0_count", count, 1);
    step();
    check("sim_empty", bus.out_valid, 0);

    // Random traffic through wrapping pointers, checked against a queue
    q = {};
    next_word = 8'h01;
    got = 0;
    done = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (!bus.in_valid || q.size() < 4) begin
        bus.in_valid = (next_word <= 8'h0A) && ($urandom_range(0, 3) != 0);
      end
      bus.in_data   = next_word;
      bus.out_ready = ($urandom_range(0, 1) == 1);
      check("wrap_count", count, q.size());
      check("wrap_bound", (count <= 3'd4), 1);
      check("wrap_ovalid", bus.out_valid, (q.size() != 0));
      if (q.size() != 0) begin
        check("wrap_head", bus.out_data, q[0]);
      end
      if (bus.out_ready && q.size() != 0) begin
        void'(q.pop_front());
        got++;
      end
      if (bus.in_valid && (count != 3'd4)) begin
        q.push_back(next_word);
        next_word++;
      end
      step();
      if (got == 10) done = 1'b1;
    end
    check("wrap_all_received", got, 10);
    check("wrap_final_count", count, 0);

    // Clear beats a simultaneous push and pop
    drive(1'b1, 8'hE1, 1'b0, 1'b0); step();
    drive(1'b1, 8'hE2, 1'b0, 1'b0); step();
    drive(1'b1, 8'hE3, 1'b0, 1'b0); step();
    check("clr_pre_count", count, 3);
    drive(1'b1, 8'h77, 1'b1, 1'b1); step();
    check("clr_count", count, 0); check("clr_ovalid", bus.out_valid, 0);
    check("clr_iready", bus.in_ready, 1);
    drive(1'b0, 8'h00, 1'b1, 1'b0); step();
    check("clr_no77", (bus.out_data != 8'h77), 1); check("clr_stays_empty", count, 0);
    drive(1'b1, 8'h88, 1'b0, 1'b0); step();
    check("clr_after_head", bus.out_data, 8'h88); check("clr_after_count", count, 1);

    // Async reset mid-cycle with data buffered and overflow set
    drive(1'b1, 8'h99, 1'b0, 1'b0); step();
    drive(1'b1, 8'hAA, 1'b0, 1'b0); step();
    drive(1'b1, 8'hBB, 1'b0, 1'b0); step();
    drive(1'b1, 8'hCC, 1'b0, 1'b0); step();
    check("arst_pre_ovf", overflow, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_count",    count,         0);
    check("arst_ovalid",   bus.out_valid, 0);
    check("arst_iready",   bus.in_ready,  1);
    check("arst_overflow", overflow,      0);
    check("arst_out_data", bus.out_data,  0);
    check("arst_afull",    almost_full,   0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #3 reset_n = 1'b1;
    drive(1'b1, 8'h5A, 1'b0, 1'b0); step();
    check("post_rst_head", bus.out_data, 8'h5A); check("post_rst_count", count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
